render_rect_datapath: RTL and testbench

Datapath partner of the rectangle-draw control FSM. Captures the x/y origin and colour while the controller asserts its load strobes. On a start_count pulse, it scans a fixed W x H box pixel by pixel. Each cycle it drives one (x, y, colour, plot) write to the VGA adapter, and it reports busy/done back to the controller.

---
 rtl/render_rect_datapath.sv | 159 +++++++++++++++
 tb/tb_render_rect_datapath.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/render_rect_datapath.sv
// Rectangle-draw datapath: captures origin/colour, then scans a BOX_W x BOX_H box one pixel per cycle.
// Build macro RECT_CLIP_EN: pixels whose unwrapped coordinate leaves SCREEN_W x SCREEN_H get plot=0.
module render_rect_datapath #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 3,
    parameter int BOX_W    = 4,
    parameter int BOX_H    = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [X_W-1:0] data_in,
    input  logic [C_W-1:0] colour_in,
    input  logic           ld_x,
    input  logic           ld_y,
    input  logic           start_count,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [C_W-1:0] colour_out,
    output logic           plot,
    output logic           busy,
    output logic           done,
    output logic [1:0]     state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [X_W-1:0] CX_LAST = X_W'(BOX_W - 1);
    localparam logic [Y_W-1:0] CY_LAST = Y_W'(BOX_H - 1);

    if (BOX_W < 1 || BOX_W > (1 << X_W) || BOX_H < 1 || BOX_H > (1 << Y_W) ||
        SCREEN_W < 1 || SCREEN_H < 1) begin : g_param_check
        $error("render_rect_datapath: parameter out of range");
    end

    state_t         state, state_n;
    logic [X_W-1:0] x_reg, x_snap, cx, cx_n;
    logic [Y_W-1:0] y_reg, y_snap, cy, cy_n;
    logic [C_W-1:0] c_reg, c_snap;
    logic           start_box;
    logic [X_W-1:0] x_base, sum_x;
    logic [Y_W-1:0] y_base, sum_y;
    logic [C_W-1:0] c_base;
    logic           in_bounds;

    // plot acts as a valid strobe toward the VGA adapter: one pixel per cycle
    // while high, no ready/backpressure; the adapter must accept every plot cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_box = 1'b0;
        cx_n      = cx;
        cy_n      = cy;
        unique case (state)
            IDLE: begin
                if (start_count) begin
                    state_n   = DRAW;
                    start_box = 1'b1;
                    cx_n      = '0;
                    cy_n      = '0;
                end
            end
            DRAW: begin
                if (cx == CX_LAST) begin
                    cx_n = '0;
                    if (cy == CY_LAST) begin
                        cy_n    = '0;
                        state_n = DONE;
                    end else begin
                        cy_n = cy + 1'b1;
                    end
                end else begin
                    cx_n = cx + 1'b1;
                end
            end
            DONE: begin
                if (start_count) begin
                    state_n   = DRAW;
                    start_box = 1'b1;
                    cx_n      = '0;
                    cy_n      = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The box starting this edge uses the live origin registers, not the stale snapshot.
    assign x_base = start_box ? x_reg : x_snap;
    assign y_base = start_box ? y_reg : y_snap;
    assign c_base = start_box ? c_reg : c_snap;
    assign sum_x  = x_base + cx_n;
    assign sum_y  = y_base + cy_n;

`ifdef RECT_CLIP_EN
    logic [X_W:0] wide_x;
    logic [Y_W:0] wide_y;
    assign wide_x    = {1'b0, x_base} + {1'b0, cx_n};
    assign wide_y    = {1'b0, y_base} + {1'b0, cy_n};
    assign in_bounds = (32'(wide_x) < 32'(SCREEN_W)) && (32'(wide_y) < 32'(SCREEN_H));
`else
    assign in_bounds = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg      <= '0;
            y_reg      <= '0;
            c_reg      <= '0;
            x_snap     <= '0;
            y_snap     <= '0;
            c_snap     <= '0;
            cx         <= '0;
            cy         <= '0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            cx <= cx_n;
            cy <= cy_n;
            if (ld_x) x_reg <= data_in;
            if (ld_y) begin
                y_reg <= data_in[Y_W-1:0];
                c_reg <= colour_in;
            end
            if (start_box) begin
                x_snap <= x_reg;
                y_snap <= y_reg;
                c_snap <= c_reg;
            end
            plot <= (state_n == DRAW) && in_bounds;
            busy <= (state_n == DRAW);
            done <= (state_n == DONE);
            if (state_n == DRAW) begin
                x_out      <= sum_x;
                y_out      <= sum_y;
                colour_out <= c_base;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_render_rect_datapath.sv
// Bench for render_rect_datapath: directed scenarios plus random load/start traffic,
// scored against a box-level model of expected pixels and done pulses keyed by clock edge.
module tb_render_rect_datapath;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;
    localparam int BOX_W    = 4;
    localparam int BOX_H    = 4;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int PW       = 32 + X_W + Y_W + C_W;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [X_W-1:0] data_in = '0;
    logic [C_W-1:0] colour_in = '0;
    logic           ld_x = 1'b0;
    logic           ld_y = 1'b0;
    logic           start_count = 1'b0;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic [C_W-1:0] colour_out;
    logic           plot;
    logic           busy;
    logic           done;
    logic [1:0]     state_dbg;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;

    // Expected pixels as {edge, x, y, colour}; expected done pulses as edge numbers.
    logic [PW-1:0] exp_q[$];
    logic [31:0]   done_q[$];

    // Reference state: origin registers and first edge at which a new start is accepted.
    int mx = 0;
    int my = 0;
    int mc = 0;
    int next_accept = 0;

    render_rect_datapath #(
        .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .BOX_W(BOX_W), .BOX_H(BOX_H),
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .colour_in(colour_in),
        .ld_x(ld_x), .ld_y(ld_y), .start_count(start_count),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .plot(plot), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h want %0h", name, edge_cnt, act, req);
        end
    endtask

    function automatic logic [PW-1:0] pk(input int e, input int x, input int y, input int c);
        logic [31:0]    ev;
        logic [X_W-1:0] xv;
        logic [Y_W-1:0] yv;
        logic [C_W-1:0] cv;
        ev = 32'(e);
        xv = X_W'(x);
        yv = Y_W'(y);
        cv = C_W'(c);
        return {ev, xv, yv, cv};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit lx, input bit ly, input int d, input int c, input bit st);
        int m;
        @(negedge clk);
        ld_x        = lx;
        ld_y        = ly;
        data_in     = X_W'(d);
        colour_in   = C_W'(c);
        start_count = st;
        m = edge_cnt + 1;
        if (st && m >= next_accept) begin
            for (int j = 0; j < BOX_H; j++) begin
                for (int i = 0; i < BOX_W; i++) begin
                    int ux;
                    int uy;
                    bit vis;
                    ux  = mx + i;
                    uy  = my + j;
                    vis = 1'b1;
`ifdef RECT_CLIP_EN
                    vis = (ux < SCREEN_W) && (uy < SCREEN_H);
`endif
                    if (vis)
                        exp_q.push_back(pk(m + j * BOX_W + i, ux % (1 << X_W), uy % (1 << Y_W), mc));
                end
            end
            done_q.push_back(32'(m + BOX_W * BOX_H));
            next_accept = m + BOX_W * BOX_H + 1;
        end
        if (lx) mx = d % (1 << X_W);
        if (ly) begin
            my = d % (1 << Y_W);
            mc = c % (1 << C_W);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic start_box();
        drive(1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic load_origin(input int x, input int y, input int c);
        drive(1'b1, 1'b0, x, 0, 1'b0);
        drive(1'b0, 1'b1, y, c, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_x"}, x_out, 0);
        check({tag, "_y"}, y_out, 0);
        check({tag, "_colour"}, colour_out, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    task automatic reset_mid_draw();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_quiet("reset_mid");
        exp_q.delete();
        done_q.delete();
        mx = 0;
        my = 0;
        mc = 0;
        next_accept = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [PW-1:0] e;
        bit            exp_pix;
        bit            exp_done;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                exp_pix = (exp_q.size() > 0) && (exp_q[0][PW-1 -: 32] == 32'(edge_cnt));
                if (plot || exp_pix) check("plot_at_edge", plot, exp_pix);
                if (exp_pix) begin
                    e = exp_q.pop_front();
                    if (plot) check("pixel", {32'(edge_cnt), x_out, y_out, colour_out}, e);
                end
                if (plot) check("busy_while_plot", busy, 1);

                exp_done = (done_q.size() > 0) && (done_q[0] == 32'(edge_cnt));
                if (done || exp_done) check("done_at_edge", done, exp_done);
                if (exp_done) void'(done_q.pop_front());
                if (done) check("busy_at_done", busy, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int drain;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;

        // basic box at (10,20) colour 5
        load_origin(10, 20, 5);
        start_box();
        idle(20);
        check("basic_busy_after", busy, 0);
        check("basic_state_after", state_dbg, 0);

        // origin reload mid-draw must not disturb the running box
        load_origin(0, 0, 2);
        start_box();
        idle(4);
        drive(1'b1, 1'b0, 100, 0, 1'b0);
        idle(14);
        start_box();
        idle(20);

        // second start during a draw is ignored
        start_box();
        idle(7);
        start_box();
        idle(12);

        // back-to-back: start in the done cycle
        start_box();
        idle(16);
        start_box();
        idle(20);

        // coordinate wrap (or full clip when clipping is built in)
        load_origin(254, 126, 6);
        start_box();
        idle(20);

        // reset mid-draw, then a box from the cleared registers
        load_origin(30, 40, 7);
        start_box();
        idle(5);
        reset_mid_draw();
        idle(3);
        start_box();
        idle(20);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            bit lx;
            bit ly;
            bit st;
            lx = ($urandom_range(0, 99) < 8);
            ly = ($urandom_range(0, 99) < 8);
            st = ($urandom_range(0, 9) == 0);
            drive(lx, ly, int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), st);
        end

        drain = 0;
        while ((exp_q.size() > 0 || done_q.size() > 0) && drain < 200) begin
            idle(1);
            drain++;
        end
        idle(2);
        check("drain_pixels", exp_q.size(), 0);
        check("drain_done", done_q.size(), 0);
        check("final_busy", busy, 0);
        check("final_plot", plot, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
